mem_sum_core: RTL
=================

# mem_sum_core

Self-contained, parametrised accumulate engine: on a start pulse it sums the arithmetic series 1, 1+S, 1+2S, … up to a limit L and returns the result with a done pulse. It joins the dedicated control unit to an internal 4-entry register file and a datapath of 2:1 source mux, adder and comparator in one block. It generalises the fixed 8-bit, limit-10, step-1 sum datapath in three ways:

- configurable width;
- run-time limit and step;
- overflow reporting.

## Interface

Parameters:
- DATA_W, 8, width of data, limit, step and every register-file entry (≥ 2)

Ports:
- iClk  in  1  clock, rising edge
- iRst  in  1  reset, asynchronous, active-high
- iStart  in  1  start request, sampled only in IDLE
- iLimit  in  DATA_W  last-term bound L (unsigned), latched at start accept
- iStep  in  DATA_W  term increment S (unsigned), latched at start accept; 0 is treated as 1
- oBusy  out  1  high from the cycle after accept through the DONE cycle inclusive
- oDone  out  1  one-cycle pulse in the DONE state
- oSum  out  DATA_W  result of last completed run, held until the next DONE
- oOvf  out  1  overflow flag of last completed run, held with oSum

## Operation

- Register file: 4 × DATA_W, two asynchronous read ports, one synchronous write port. Entries: R0 = sum, R1 = term index, R2 = step, R3 = limit.
- Write-data mux: selects constant 0, constant 1, or adder output.
- FSM states:
  - IDLE: on iStart, write R3 ← iLimit and latch step into R2, with 0 converted to 1. Step is captured in the same cycle through a dedicated step register write path. Go to INIT0.
  - INIT0: R0 ← 0; clear the wrap flag and the run overflow flag. Go to INIT1.
  - INIT1: R1 ← 1. Go to CHECK.
  - CHECK: if the wrap flag is clear and R1 ≤ R3, go to ADD; else go to DONE.
  - ADD: R0 ← R0 + R1, modulo 2^DATA_W. A carry out sets the run overflow flag. Go to INC.
  - INC: R1 ← R1 + R2. A carry out sets the wrap flag. Go to CHECK.
  - DONE: oSum ← R0, oOvf ← run overflow flag, oDone = 1. Go to IDLE.
- Comparison is unsigned.
- A wrap of the index always terminates the loop, so the FSM cannot spin forever for any L or S.
- Number of terms N = 0 if L = 0, else floor((L−1)/S)+1 (S after the 0→1 substitution).
- iStart while oBusy, or during DONE, is ignored; no queuing.
- iLimit and iStep changes after accept have no effect on the current run.

## Timing

- Accept at clock edge 0 (IDLE with iStart = 1); oBusy rises after edge 0.
- Cycle-by-cycle schedule:
  - INIT0 occupies cycle 1 and INIT1 cycle 2.
  - Each term costs 3 cycles (CHECK/ADD/INC).
  - The final CHECK is cycle 3N+3.
  - DONE is cycle 3N+4.
- oDone is high for exactly the single cycle 3N+4. oSum and oOvf update at the edge ending DONE and are stable from cycle 3N+5.
- oBusy falls after the DONE cycle. A new iStart is accepted in the first IDLE cycle, giving back-to-back runs with one idle cycle.
- Reset values: state IDLE, all register-file entries 0, wrap and run flags 0, oBusy 0, oDone 0, oSum 0, oOvf 0.
- Reset asserted mid-run aborts immediately (asynchronous). No oDone is produced, and previous oSum/oOvf are cleared to 0.

## Configuration

- Macro MEM_SUM_OVF_EN:
  - Defined: the adder carry-out drives the run overflow flag, and oOvf reports it as specified above.
  - Not defined: the overflow logic is omitted and oOvf is tied to 0. oSum is still the modulo-2^DATA_W sum, and cycle timing is identical.
- The index wrap flag is always present, independent of the macro.

## Test plan

- DATA_W=8, L=10, S=1, single start pulse → oDone in cycle 34 after accept, oSum=55, oOvf=0, oBusy high cycles 1–34.
- L=10, S=2 → terms 1,3,5,7,9; oDone at cycle 19, oSum=25. Repeat with S=0 → behaves as S=1, oSum=55 at cycle 34.
- L=0 → oDone at cycle 4, oSum=0, oOvf=0. L=1 → oDone at cycle 7, oSum=1.
- L=255, S=1, DATA_W=8 → N=255, index wrap terminates, oDone at cycle 769, oSum=128 (32640 mod 256), oOvf=1 with MEM_SUM_OVF_EN and 0 without.
- iStart pulsed at cycles 5 and 34 of an L=10 run, with iLimit changed to 3 mid-run → both ignored, result 55. The next iStart in the IDLE cycle (cycle 35) with L=3 yields oSum=6 after 13 more cycles.
- iRst asserted in cycle 20 of an L=10 run → oBusy, oDone, oSum, oOvf all 0 asynchronously. After release, a fresh L=4 run returns oSum=10 at cycle 16.

Source files
------------

// File: rtl/mem_sum_core.sv
// mem_sum_core -- arithmetic-series accumulate engine.
//
// On an accepted start the block sums the terms 1, 1+S, 1+2S, ... that do
// not exceed the limit L, then presents the result with a one-cycle done
// pulse. A small FSM drives a 4-entry register file (R0 sum, R1 term index,
// R2 step, R3 limit) through a shared adder and an unsigned comparator.
// Every term costs three cycles (CHECK, ADD, INC).
//
// Optional feature: define MEM_SUM_OVF_EN to report adder carry-out of the
// sum on oOvf; when undefined oOvf is tied to 0 and timing is unchanged.
//
// Parameters:
//   DATA_W  width of data, limit, step and register-file entries (>= 2)
// Ports:
//   iClk    in   clock, rising edge
//   iRst    in   asynchronous active-high reset
//   iStart  in   start request, sampled only in IDLE
//   iLimit  in   last-term bound L (unsigned), latched at accept
//   iStep   in   term increment S (unsigned), latched at accept, 0 -> 1
//   oBusy   out  high from the cycle after accept through DONE
//   oDone   out  one-cycle pulse in DONE
//   oSum    out  result of last completed run
//   oOvf    out  overflow flag of last completed run
module mem_sum_core #(
  parameter int DATA_W = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [DATA_W-1:0] iLimit,
  input  logic [DATA_W-1:0] iStep,
  output logic              oBusy,
  output logic              oDone,
  output logic [DATA_W-1:0] oSum,
  output logic              oOvf
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT0 = 3'd1;
  localparam logic [2:0] S_INIT1 = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_ADD   = 3'd4;
  localparam logic [2:0] S_INC   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [1:0] WSEL_ZERO = 2'd0;
  localparam logic [1:0] WSEL_ONE  = 2'd1;
  localparam logic [1:0] WSEL_ADD  = 2'd2;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [DATA_W-1:0] rf [0:3];
  logic              wrap_flag;

  logic [1:0]        rd_a_addr;
  logic [1:0]        rd_b_addr;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W:0]   add_full;
  logic              add_carry;
  logic              idx_le_limit;

  logic              wr_en;
  logic [1:0]        wr_addr;
  logic [1:0]        wr_sel;
  logic [DATA_W-1:0] wr_data;

  logic              accept;
  logic [DATA_W-1:0] step_fix;

  assign accept   = (state == S_IDLE) && iStart;
  assign step_fix = (iStep == '0) ? DATA_W'(1) : iStep;

  // Port A: sum during ADD, index otherwise (the 2:1 source mux).
  // Port B: index during ADD, step during INC, limit during CHECK.
  always_comb begin
    rd_a_addr = (state == S_ADD) ? 2'd0 : 2'd1;
    rd_b_addr = 2'd3;
    if (state == S_ADD)      rd_b_addr = 2'd1;
    else if (state == S_INC) rd_b_addr = 2'd2;
  end

  assign rd_a         = rf[rd_a_addr];
  assign rd_b         = rf[rd_b_addr];
  assign add_full     = {1'b0, rd_a} + {1'b0, rd_b};
  assign add_carry    = add_full[DATA_W];
  assign idx_le_limit = (rd_a <= rd_b);

  always_comb begin
    case (wr_sel)
      WSEL_ZERO: wr_data = '0;
      WSEL_ONE:  wr_data = DATA_W'(1);
      default:   wr_data = add_full[DATA_W-1:0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = 2'd0;
    wr_sel    = WSEL_ZERO;
    case (state)
      S_IDLE:  if (iStart) state_nxt = S_INIT0;
      S_INIT0: begin
        wr_en     = 1'b1;
        wr_addr   = 2'd0;
        wr_sel    = WSEL_ZERO;
        state_nxt = S_INIT1;
      end
      S_INIT1: begin
        wr_en     = 1'b1;
        wr_addr   = 2'd1;
        wr_sel    = WSEL_ONE;
        state_nxt = S_CHECK;
      end
      // A wrapped index is never compared: it always ends the run.
      S_CHECK: state_nxt = (!wrap_flag && idx_le_limit) ? S_ADD : S_DONE;
      S_ADD: begin
        wr_en     = 1'b1;
        wr_addr   = 2'd0;
        wr_sel    = WSEL_ADD;
        state_nxt = S_INC;
      end
      S_INC: begin
        wr_en     = 1'b1;
        wr_addr   = 2'd1;
        wr_sel    = WSEL_ADD;
        state_nxt = S_CHECK;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Limit and step are loaded through dedicated paths on accept; the
  // general write port serves R0/R1 during the run.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      if (accept) begin
        rf[3] <= iLimit;
        rf[2] <= step_fix;
      end
      if (wr_en) rf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wrap_flag <= 1'b0;
    end else if (state == S_INIT0) begin
      wrap_flag <= 1'b0;
    end else if (state == S_INC && add_carry) begin
      wrap_flag <= 1'b1;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oSum <= '0;
    end else if (state == S_DONE) begin
      oSum <= rf[0];
    end
  end

`ifdef MEM_SUM_OVF_EN
  logic run_ovf;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      run_ovf <= 1'b0;
    end else if (state == S_INIT0) begin
      run_ovf <= 1'b0;
    end else if (state == S_ADD && add_carry) begin
      run_ovf <= 1'b1;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oOvf <= 1'b0;
    end else if (state == S_DONE) begin
      oOvf <= run_ovf;
    end
  end
`else
  assign oOvf = 1'b0;
`endif

  assign oBusy = (state != S_IDLE);
  assign oDone = (state == S_DONE);

endmodule
